// File: rtl/vga_disp_ctr.sv
// Display-position counter: turns the active-video pixel strobe into word address and pixel-in-word counters.
// Optional sequencing checker on err_o is enabled by defining VGA_DISP_CTR_CHECK_EN.
module vga_disp_ctr #(
  parameter int MEM_ADDR_WIDTH  = 16,
  parameter int ROW_CTR_WIDTH   = 3,
  parameter int MAX_PXL_CNT     = 7,
  parameter int WORDS_PER_LINE  = 80,
  parameter int LINES_PER_FRAME = 480,
  parameter int LINE_REPEAT     = 1
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      frame_start_i,
  input  logic                      pxl_en_i,
  output logic [MEM_ADDR_WIDTH-1:0] disp_addr_ctr_o,
  output logic [ROW_CTR_WIDTH-1:0]  disp_pxl_ctr_o,
  output logic                      line_done_o,
  output logic                      frame_done_o,
  output logic                      err_o
);

  localparam int WORD_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int LINE_W = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
  localparam int REP_W  = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;

  localparam logic [ROW_CTR_WIDTH-1:0]  LAST_PXL    = ROW_CTR_WIDTH'(MAX_PXL_CNT);
  localparam logic [WORD_W-1:0]         LAST_WORD   = WORD_W'(WORDS_PER_LINE - 1);
  localparam logic [LINE_W-1:0]         LAST_LINE   = LINE_W'(LINES_PER_FRAME - 1);
  localparam logic [REP_W-1:0]          LAST_REP    = REP_W'(LINE_REPEAT - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] LINE_STRIDE = MEM_ADDR_WIDTH'(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_LINE  = 2'd1,
    LINE       = 2'd2,
    FRAME_DONE = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [ROW_CTR_WIDTH-1:0]  pxl_q, pxl_d;
  logic [WORD_W-1:0]         word_q, word_d;
  logic [LINE_W-1:0]         line_q, line_d;
  logic [REP_W-1:0]          rep_q, rep_d;
  logic                      line_done_q, line_done_d;
  logic                      frame_done_q, frame_done_d;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    base_d       = base_q;
    pxl_d        = pxl_q;
    word_d       = word_q;
    line_d       = line_q;
    rep_d        = rep_q;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;

    if (frame_start_i) begin
      state_d = WAIT_LINE;
      addr_d  = '0;
      base_d  = '0;
      pxl_d   = '0;
      word_d  = '0;
      line_d  = '0;
      rep_d   = '0;
    end else begin
      case (state_q)
        WAIT_LINE, LINE: begin
          if (pxl_en_i) begin
            state_d = LINE;
            if (pxl_q != LAST_PXL) begin
              pxl_d = pxl_q + ROW_CTR_WIDTH'(1);
            end else begin
              pxl_d = '0;
              if (word_q != LAST_WORD) begin
                word_d = word_q + WORD_W'(1);
                addr_d = addr_q + MEM_ADDR_WIDTH'(1);
              end else begin
                word_d      = '0;
                line_done_d = 1'b1;
                if (rep_q != LAST_REP) begin
                  // Replay the same memory row for vertical scaling.
                  rep_d   = rep_q + REP_W'(1);
                  addr_d  = base_q;
                  state_d = WAIT_LINE;
                end else begin
                  rep_d = '0;
                  if (line_q == LAST_LINE) begin
                    line_d       = '0;
                    base_d       = '0;
                    addr_d       = '0;
                    frame_done_d = 1'b1;
                    state_d      = FRAME_DONE;
                  end else begin
                    line_d  = line_q + LINE_W'(1);
                    base_d  = base_q + LINE_STRIDE;
                    addr_d  = base_q + LINE_STRIDE;
                    state_d = WAIT_LINE;
                  end
                end
              end
            end
          end
        end
        IDLE, FRAME_DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      base_q       <= '0;
      pxl_q        <= '0;
      word_q       <= '0;
      line_q       <= '0;
      rep_q        <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      base_q       <= base_d;
      pxl_q        <= pxl_d;
      word_q       <= word_d;
      line_q       <= line_d;
      rep_q        <= rep_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign disp_addr_ctr_o = addr_q;
  assign disp_pxl_ctr_o  = pxl_q;
  assign line_done_o     = line_done_q;
  assign frame_done_o    = frame_done_q;

`ifdef VGA_DISP_CTR_CHECK_EN
  logic err_q, err_d;

  // Sticky until a clean restart after a completed frame.
  always_comb begin
    err_d = err_q;
    if (frame_start_i && (state_q == FRAME_DONE)) begin
      err_d = 1'b0;
    end else if ((pxl_en_i && ((state_q == IDLE) || (state_q == FRAME_DONE))) ||
                 (frame_start_i && (state_q == LINE)) ||
                 (frame_start_i && (state_q == WAIT_LINE) && (line_q != '0))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vga_disp_ctr.sv
// Scoreboard bench for vga_disp_ctr: 2 words/line, 3 rows/frame, each row shown twice, 8 pixels/word.
module tb_vga_disp_ctr;

`ifdef VGA_DISP_CTR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        frame_start;
  logic        pxl_en;
  logic [15:0] addr;
  logic [2:0]  pxl;
  logic        line_done;
  logic        frame_done;
  logic        err;

  vga_disp_ctr #(
    .MEM_ADDR_WIDTH (16),
    .ROW_CTR_WIDTH  (3),
    .MAX_PXL_CNT    (7),
    .WORDS_PER_LINE (2),
    .LINES_PER_FRAME(3),
    .LINE_REPEAT    (2)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .frame_start_i  (frame_start),
    .pxl_en_i       (pxl_en),
    .disp_addr_ctr_o(addr),
    .disp_pxl_ctr_o (pxl),
    .line_done_o    (line_done),
    .frame_done_o   (frame_done),
    .err_o          (err)
  );

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [2:0]  pxl;
    logic        ld;
    logic        fd;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   exp_err = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation whose cycle has come due.
  always @(negedge clk or negedge rstn) begin
    exp_t e;
    #1;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (addr !== e.addr || pxl !== e.pxl || line_done !== e.ld ||
          frame_done !== e.fd || err !== e.err) begin
        failures++;
        $display("FAIL outputs cyc=%0d got addr=%0d pxl=%0d ld=%b fd=%b err=%b want addr=%0d pxl=%0d ld=%b fd=%b err=%b",
                 e.cyc, addr, pxl, line_done, frame_done, err,
                 e.addr, e.pxl, e.ld, e.fd, e.err);
      end
    end
  end

  function automatic exp_t mk(input int c, input int a, input int p, input bit ld, input bit fd);
    exp_t e;
    e.cyc  = c;
    e.addr = 16'(a);
    e.pxl  = 3'(p);
    e.ld   = ld;
    e.fd   = fd;
    e.err  = exp_err;
    return e;
  endfunction

  // Drive one cycle of inputs and expect the outputs after the coming edge.
  task automatic step(input bit f, input bit e, input int a, input int p, input bit ld, input bit fd);
    frame_start = f;
    pxl_en      = e;
    exp_q.push_back(mk(cyc + 1, a, p, ld, fd));
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int base, input int nbase, input bit fd, input int gap_at);
    for (int i = 0; i < 16; i++) begin
      if (i == gap_at) repeat (3) step(1'b0, 1'b0, base + i / 8, i % 8, 1'b0, 1'b0);
      if (i < 15) step(1'b0, 1'b1, base + (i + 1) / 8, (i + 1) % 8, 1'b0, 1'b0);
      else        step(1'b0, 1'b1, nbase, 0, 1'b1, fd);
    end
    step(1'b0, 1'b0, nbase, 0, 1'b0, 1'b0);
  endtask

  task automatic partial(input int base, input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b1, base + (i + 1) / 8, (i + 1) % 8, 1'b0, 1'b0);
  endtask

  initial begin
    rstn        = 1'b0;
    frame_start = 1'b0;
    pxl_en      = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) step(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    rstn = 1'b1;

    // Pixels with no frame start are ignored.
    exp_err = CHK;
    repeat (5) step(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

    // Full frame: each row twice, gap in the repeat of row 0.
    line(0, 0, 1'b0, -1);
    line(0, 2, 1'b0, 4);
    line(2, 2, 1'b0, -1);
    line(2, 4, 1'b0, -1);
    line(4, 4, 1'b0, -1);
    line(4, 0, 1'b1, -1);
    repeat (3) step(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);

    // Restart from FRAME_DONE clears the error flag.
    exp_err = 1'b0;
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    line(0, 0, 1'b0, -1);
    line(0, 2, 1'b0, -1);
    partial(2, 10);

    // Frame start mid-line with a coincident pixel: pixel not counted.
    exp_err = CHK;
    step(1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    for (int k = 1; k <= 13; k++) step(1'b0, 1'b1, k / 8, k % 8, 1'b0, 1'b0);

    // Asynchronous reset at word 1, pixel 5.
    @(negedge clk);
    #2;
    exp_err = 1'b0;
    exp_q.push_back(mk(cyc, 0, 0, 1'b0, 1'b0));
    rstn = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    rstn = 1'b1;
    exp_err = CHK;
    repeat (3) step(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) step(1'b0, 1'b1, 0, k, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 3, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_disp_ctr.md
Name: vga_disp_ctr

Overview:
- Display-position counter stage that sits directly upstream of the VGA memory double buffer.
- Converts the timing generator's active-video pixel strobe into the two position signals the buffer consumes: the word address counter and the pixel-within-word counter.
- Supports integer vertical scaling by replaying each memory row LINE_REPEAT times.
- Reports line and frame completion.

Parameters:
- MEM_ADDR_WIDTH, 16: width of the address counter. WORDS_PER_LINE*LINES_PER_FRAME must be <= 2**MEM_ADDR_WIDTH.
- ROW_CTR_WIDTH, 3: width of the pixel-within-word counter.
- MAX_PXL_CNT, 7: index of the last pixel in a memory word (pixels per word minus 1).
- WORDS_PER_LINE, 80: memory words per displayed line. Must be >= 1.
- LINES_PER_FRAME, 480: distinct memory rows per frame.
- LINE_REPEAT, 1: times each memory row is displayed. Must be >= 1.

Ports:
- clk_i  in  1  pixel clock.
- rstn_i  in  1  asynchronous active-low reset.
- frame_start_i  in  1  one-cycle pulse at the start of each frame (vsync).
- pxl_en_i  in  1  high for every visible pixel cycle (h_active AND v_active).
- disp_addr_ctr_o  out  MEM_ADDR_WIDTH  word address of the pixel shown this cycle.
- disp_pxl_ctr_o  out  ROW_CTR_WIDTH  pixel index within the word shown this cycle.
- line_done_o  out  1  one-cycle pulse after the last pixel of a line.
- frame_done_o  out  1  one-cycle pulse after the last pixel of a frame.
- err_o  out  1  sequencing error flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, rstn_i=0): all outputs 0; base address, word index, line counter and repeat counter all 0; state IDLE.
- All outputs are registered.
- When pxl_en_i=1, disp_addr_ctr_o and disp_pxl_ctr_o already hold the position of the pixel displayed in that cycle. Counters advance on the clock edge that ends the cycle.
- States:
  - IDLE: pxl_en_i ignored. frame_start_i -> WAIT_LINE.
  - WAIT_LINE: counters hold. pxl_en_i=1 -> LINE; that cycle's pixel is counted.
  - LINE: each pxl_en_i cycle increments disp_pxl_ctr_o. At MAX_PXL_CNT it wraps to 0 and both the word index and disp_addr_ctr_o increment. pxl_en_i=0 mid-line holds the counters with no state change.
  - On the last pixel of a line (word index = WORDS_PER_LINE-1, pixel = MAX_PXL_CNT):
    - next cycle line_done_o=1 and disp_pxl_ctr_o=0;
    - if repeat counter < LINE_REPEAT-1: repeat counter +1, disp_addr_ctr_o returns to line base;
    - otherwise: repeat counter=0, line counter +1, base += WORDS_PER_LINE, disp_addr_ctr_o = new base;
    - state -> WAIT_LINE, or FRAME_DONE if line counter reaches LINES_PER_FRAME.
  - FRAME_DONE: frame_done_o pulses for exactly the entry cycle, coincident with the final line_done_o. pxl_en_i is ignored. disp_addr_ctr_o = 0 and disp_pxl_ctr_o = 0. frame_start_i -> WAIT_LINE.
- frame_start_i in any state has priority: all counters and base clear to 0, state -> WAIT_LINE, and a coincident pxl_en_i is not counted.
- No address arithmetic ever exceeds WORDS_PER_LINE*LINES_PER_FRAME-1. The base wraps to 0 only through FRAME_DONE or frame_start_i.
- Reset asserted mid-line: outputs clear immediately. After release the block waits in IDLE for frame_start_i.

Optional Feature:
- Macro: VGA_DISP_CTR_CHECK_EN.
- Defined: err_o is set (sticky) when any of the following occurs:
  - pxl_en_i=1 in IDLE or FRAME_DONE;
  - frame_start_i arrives while in LINE with a partially consumed line;
  - frame_start_i arrives in WAIT_LINE with line counter != 0, i.e. frame ended early.
- err_o clears only on reset or on a frame_start_i that arrives from FRAME_DONE.
- Not defined: err_o is tied to 0, no checker logic is present, and all other behaviour is identical.

Test Plan (WORDS_PER_LINE=2, LINES_PER_FRAME=3, LINE_REPEAT=2, MAX_PXL_CNT=7):
- Reset, then 5 pxl_en_i cycles with no frame_start_i -> all outputs stay 0, err_o=1 only with the macro defined.
- frame_start_i, then 16 contiguous pxl_en_i cycles -> pxl 0..7 at addr 0, then pxl 0..7 at addr 1; line_done_o=1 the next cycle; addr returns to 0.
- Second line (the repeat) of 16 pixels -> addr 0,1 again; afterwards addr=2 and line_done_o pulses. Insert a 3-cycle pxl_en_i gap at pixel 4 -> counters hold through the gap and resume at 5.
- Full frame of 6 lines -> addr sequence 0-1,0-1,2-3,2-3,4-5,4-5; frame_done_o pulses with the 6th line_done_o; outputs are 0 and further pxl_en_i is ignored until frame_start_i.
- frame_start_i after 10 pixels of line 3 -> next cycle addr=0 and pxl=0; err_o=1 with the macro, 0 without.
- rstn_i pulsed low at pixel 5 of word 1 -> outputs 0 asynchronously; after release, pxl_en_i is ignored until frame_start_i, after which counting restarts from addr 0, pxl 0.
